// File: rtl/ptcalc_scale_pkg.sv
// Shared defaults, rounding helper and payload types for the product scale/saturate stage.
package ptcalc_scale_pkg;

  localparam int unsigned PROD_W_DEF = 29;
  localparam int unsigned PT_W_DEF   = 9;
  localparam int unsigned SHIFT_DEF  = 12;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned SUM_W      = PROD_W_DEF + 2;

  // Half an LSB of the post-shift result; zero when nothing is shifted out.
  function automatic logic [63:0] round_const(input int unsigned shift);
    logic [63:0] r;
    r = '0;
    if (shift > 0) r[shift-1] = 1'b1;
    return r;
  endfunction

  localparam logic [SUM_W-1:0] ROUND_C = SUM_W'(round_const(SHIFT_DEF));

  typedef logic signed [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic [PT_W_DEF-1:0] pt;
    logic                sat_hi;
    logic                sat_lo;
  } pt_out_t;

endpackage

// File: rtl/ptcalc_pipe_reg.sv
// Single valid/ready register slice; accepts new data when empty or when its contents leave.
module ptcalc_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_ready = !i_rst && (!r_valid || i_ready);
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ptcalc_prod_scale_sat.sv
// Offset, round-half-up, arithmetic shift and unsigned clamp of the segment product into a pT code,
// with a two-slice valid/ready pipeline and a sticky saturation event counter.
module ptcalc_prod_scale_sat
  import ptcalc_scale_pkg::*;
#(
  parameter int unsigned              PROD_W = PROD_W_DEF,
  parameter int unsigned              SHIFT  = SHIFT_DEF,
  parameter int unsigned              PT_W   = PT_W_DEF,
  parameter logic signed [PROD_W-1:0] OFFSET = '0,
  parameter int unsigned              CNT_W  = CNT_W_DEF
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] s_prod,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [PT_W-1:0]          m_pt,
  output logic                     m_sat_hi,
  output logic                     m_sat_lo,
  output logic                     m_valid,
  input  logic                     m_ready,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         sat_cnt
);

  localparam int unsigned SUM_W_L = PROD_W + 2;

  typedef logic signed [SUM_W_L-1:0] stage1_t;

  typedef struct packed {
    logic [PT_W-1:0] pt;
    logic            sat_hi;
    logic            sat_lo;
  } out_t;

  localparam stage1_t RND   = $signed(SUM_W_L'(round_const(SHIFT)));
  localparam stage1_t Q_MAX = $signed({{(SUM_W_L-PT_W){1'b0}}, {PT_W{1'b1}}});

  stage1_t          w_sum;
  stage1_t          w_st1_sum;
  stage1_t          w_q;
  logic             w_st1_valid;
  logic             w_st2_ready;
  out_t             w_out;
  out_t             w_st2_data;
  logic             w_xfer;
  logic [CNT_W-1:0] r_cnt;

  // Two guard bits absorb offset and rounding carries for any input.
  assign w_sum = SUM_W_L'(s_prod) + SUM_W_L'(OFFSET) + RND;

  ptcalc_pipe_reg #(
    .W(SUM_W_L)
  ) u_st1 (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_valid (s_valid),
    .o_ready (s_ready),
    .i_data  (w_sum),
    .o_valid (w_st1_valid),
    .i_ready (w_st2_ready),
    .o_data  (w_st1_sum)
  );

  always_comb begin
    w_q   = w_st1_sum >>> SHIFT;
    w_out = '0;
    if (w_q[SUM_W_L-1]) begin
      w_out.sat_lo = 1'b1;
    end else if (w_q > Q_MAX) begin
      w_out.pt     = '1;
      w_out.sat_hi = 1'b1;
    end else begin
      w_out.pt = w_q[PT_W-1:0];
    end
  end

  ptcalc_pipe_reg #(
    .W($bits(out_t))
  ) u_st2 (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_valid (w_st1_valid),
    .o_ready (w_st2_ready),
    .i_data  (w_out),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_data  (w_st2_data)
  );

  assign m_pt     = w_st2_data.pt;
  assign m_sat_hi = w_st2_data.sat_hi;
  assign m_sat_lo = w_st2_data.sat_lo;

  assign w_xfer = m_valid && m_ready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || clr_cnt) begin
      r_cnt <= '0;
    end else if (w_xfer && (m_sat_hi || m_sat_lo) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sat_cnt = r_cnt;

endmodule

// File: tb/tb_ptcalc_prod_scale_sat.sv
// Directed bench for the product scale/saturate stage, with parameter variants sharing one stimulus.
module tb_ptcalc_prod_scale_sat;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic signed [28:0] s_prod = '0;
  logic               s_valid = 1'b0;
  logic               m_ready = 1'b0;
  logic               clr_cnt = 1'b0;

  logic        s_ready, m_sat_hi, m_sat_lo, m_valid;
  logic [8:0]  m_pt;
  logic [15:0] sat_cnt;

  logic        rdy_c2, hi_c2, lo_c2, mv_c2;
  logic [8:0]  pt_c2;
  logic [1:0]  cnt_c2;

  logic        rdy_of, hi_of, lo_of, mv_of;
  logic [8:0]  pt_of;
  logic [15:0] cnt_of;

  logic        rdy_s0, hi_s0, lo_s0, mv_s0;
  logic [8:0]  pt_s0;
  logic [15:0] cnt_s0;

  int checks = 0;
  int errors = 0;

  logic [10:0] sn_of, sn_s0;
  logic [10:0] q[$];
  logic [10:0] exp_in, obs;
  logic        acc, outv;
  logic [8:0]  obs_pt;
  int          n_in, n_out, gaps, pr;
  logic        started;

  always #5 ap_clk = ~ap_clk;

  ptcalc_prod_scale_sat dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_prod(s_prod), .s_valid(s_valid), .s_ready(s_ready),
    .m_pt(m_pt), .m_sat_hi(m_sat_hi), .m_sat_lo(m_sat_lo), .m_valid(m_valid), .m_ready(m_ready),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  ptcalc_prod_scale_sat #(.CNT_W(2)) dut_c2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_prod(s_prod), .s_valid(s_valid), .s_ready(rdy_c2),
    .m_pt(pt_c2), .m_sat_hi(hi_c2), .m_sat_lo(lo_c2), .m_valid(mv_c2), .m_ready(m_ready),
    .clr_cnt(clr_cnt), .sat_cnt(cnt_c2)
  );

  ptcalc_prod_scale_sat #(.OFFSET(-29'sd4096)) dut_of (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_prod(s_prod), .s_valid(s_valid), .s_ready(rdy_of),
    .m_pt(pt_of), .m_sat_hi(hi_of), .m_sat_lo(lo_of), .m_valid(mv_of), .m_ready(m_ready),
    .clr_cnt(clr_cnt), .sat_cnt(cnt_of)
  );

  ptcalc_prod_scale_sat #(.SHIFT(0)) dut_s0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_prod(s_prod), .s_valid(s_valid), .s_ready(rdy_s0),
    .m_pt(pt_s0), .m_sat_hi(hi_s0), .m_sat_lo(lo_s0), .m_valid(mv_s0), .m_ready(m_ready),
    .clr_cnt(clr_cnt), .sat_cnt(cnt_s0)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Reference: floor((p + 2048) / 4096) clamped into 0..511, packed as {pt, hi, lo}.
  function automatic logic [10:0] model(input int p);
    longint s;
    s = longint'(p) + 64'sd2048;
    s = s >>> 12;
    if (s < 0)        return {9'd0, 1'b0, 1'b1};
    else if (s > 511) return {9'h1ff, 1'b1, 1'b0};
    else              return {s[8:0], 2'b00};
  endfunction

  task automatic xfer(input int p, input int ept, input logic ehi, input logic elo, input string tag);
    s_prod  = p[28:0];
    s_valid = 1'b1;
    #1;
    chk({tag, ".rdy"}, s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk({tag, ".lat"}, m_valid, 0);
    tick();
    chk({tag, ".vld"}, m_valid, 1);
    chk({tag, ".pt"}, m_pt, ept);
    chk({tag, ".hi"}, m_sat_hi, ehi);
    chk({tag, ".lo"}, m_sat_lo, elo);
    sn_of = {pt_of, hi_of, lo_of};
    sn_s0 = {pt_s0, hi_s0, lo_s0};
    tick();
    chk({tag, ".done"}, m_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst.mvalid", m_valid, 0);
    chk("rst.pt", m_pt, 0);
    chk("rst.hi", m_sat_hi, 0);
    chk("rst.lo", m_sat_lo, 0);
    chk("rst.cnt", sat_cnt, 0);
    chk("rst.sready", s_ready, 0);
    ap_rst  = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("rst.sready_rel", s_ready, 1);

    // Rounding and clamping
    xfer(411648, 101, 0, 0, "r100p5");
    xfer(409600, 100, 0, 0, "r100");
    xfer(-1, 0, 0, 0, "neg1");
    xfer(-8192, 0, 0, 1, "neg8192");
    xfer(2457600, 511, 1, 0, "p600");
    xfer(268435455, 511, 1, 0, "pmax");
    chk("cnt.three", sat_cnt, 3);
    xfer(2093056, 511, 0, 0, "p511");
    chk("cnt.unchanged", sat_cnt, 3);
    xfer(-8192, 0, 0, 1, "neg_a");
    xfer(-8192, 0, 0, 1, "neg_b");
    chk("cnt.five", sat_cnt, 5);
    chk("cnt2.stick", cnt_c2, 3);

    // Clear wins over a simultaneous saturating transfer
    m_ready = 1'b0;
    s_prod  = -29'sd8192;
    s_valid = 1'b1;
    #1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("clr.vld", m_valid, 1);
    chk("clr.lo", m_sat_lo, 1);
    m_ready = 1'b1;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr.cnt", sat_cnt, 0);
    chk("clr.cnt2", cnt_c2, 0);
    chk("clr.mvalid", m_valid, 0);

    // Offset and shift variants
    xfer(4096, 1, 0, 0, "t6a");
    chk("t6a.off", sn_of, {9'd0, 2'b00});
    chk("t6a.s0", sn_s0, {9'h1ff, 2'b10});
    xfer(5, 0, 0, 0, "t6b");
    chk("t6b.s0", sn_s0, {9'd5, 2'b00});
    chk("t6b.off", sn_of, {9'd0, 2'b01});

    // Backpressure: only two accepted while the output is stalled
    m_ready = 1'b0;
    n_in    = 0;
    for (int c = 0; c < 6; c++) begin
      s_valid = 1'b1;
      s_prod  = 29'((n_in + 1) * 4096);
      #1;
      acc = s_ready;
      tick();
      if (acc) n_in++;
    end
    chk("bp.accepted", n_in, 2);
    s_prod = 29'((n_in + 1) * 4096);
    #1;
    chk("bp.sready", s_ready, 0);
    chk("bp.hold_vld", m_valid, 1);
    chk("bp.hold_pt", m_pt, 1);

    m_ready = 1'b1;
    n_out   = 0;
    gaps    = 0;
    started = 1'b0;
    for (int c = 0; c < 40 && n_out < 6; c++) begin
      s_valid = (n_in < 6);
      s_prod  = 29'((n_in + 1) * 4096);
      #1;
      acc    = s_valid && s_ready;
      outv   = m_valid;
      obs_pt = m_pt;
      if (started && !outv) gaps++;
      tick();
      if (acc) n_in++;
      if (outv) begin
        started = 1'b1;
        n_out++;
        chk($sformatf("bp.order%0d", n_out), obs_pt, n_out);
      end
    end
    s_valid = 1'b0;
    chk("bp.count", n_out, 6);
    chk("bp.gaps", gaps, 0);
    tick();
    chk("bp.empty", m_valid, 0);

    // Random soak against the reference model
    for (int c = 0; c < 300; c++) begin
      pr      = int'($urandom_range(0, 2220000)) - 20000;
      s_prod  = pr[28:0];
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      exp_in  = model(pr);
      #1;
      acc  = s_valid && s_ready;
      outv = m_valid && m_ready;
      obs  = {m_pt, m_sat_hi, m_sat_lo};
      tick();
      if (outv) begin
        chk("soak.pending", q.size() != 0, 1);
        if (q.size() != 0) chk("soak.out", obs, q.pop_front());
      end
      if (acc) q.push_back(exp_in);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      outv = m_valid;
      obs  = {m_pt, m_sat_hi, m_sat_lo};
      tick();
      if (outv) begin
        chk("drain.pending", q.size() != 0, 1);
        if (q.size() != 0) chk("drain.out", obs, q.pop_front());
      end
    end
    chk("soak.left", q.size(), 0);

    // Reset with both stages full
    xfer(-8192, 0, 0, 1, "prefill");
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_prod  = 29'sd4096;
    tick();
    tick();
    chk("full.sready", s_ready, 0);
    chk("full.mvalid", m_valid, 1);
    ap_rst  = 1'b1;
    s_valid = 1'b0;
    tick();
    chk("rst2.mvalid", m_valid, 0);
    chk("rst2.cnt", sat_cnt, 0);
    chk("rst2.sready", s_ready, 0);
    ap_rst  = 1'b0;
    m_ready = 1'b1;
    xfer(409600, 100, 0, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
